// File: rtl/dt_pkg.sv
// Shared constants and types for the result-image packer.
// Image geometry, word width, address widths and the pack FSM state type.
package dt_pkg;
  localparam int unsigned IMG_W     = 128;
  localparam int unsigned IMG_H     = 128;
  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned RES_AW    = 14;
  localparam int unsigned STI_AW    = 10;
  localparam int unsigned RES_LAST  = IMG_W * IMG_H - 1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StLast,
    StDone
  } state_e;
endpackage

// File: rtl/pack_shift16.sv
// MSB-first word assembler.
// Shifts one bit per 'shift' into an accumulator; on the shift flagged 'last' the
// completed word is presented on 'word' with 'valid' high for exactly one cycle.
// 'word' is zero whenever 'valid' is low.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - discard any partial word (start of a pass)
//   shift, din  - shift enable and incoming bit
//   last        - this shift completes a word
//   word, valid - completed word and its one-cycle strobe
module pack_shift16
  import dt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 last,
  input  logic                 din,
  output logic [WORD_BITS-1:0] word,
  output logic                 valid
);

  logic [WORD_BITS-1:0] acc_q;
  logic [WORD_BITS-1:0] acc_next;
  logic [WORD_BITS-1:0] word_q;
  logic                 valid_q;

  always_comb begin
    acc_next = {acc_q[WORD_BITS-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= shift & last;
      word_q  <= (shift && last) ? acc_next : '0;
      if (shift) begin
        acc_q <= last ? '0 : acc_next;
      end
    end
  end

  assign word  = word_q;
  assign valid = valid_q;

endmodule

// File: rtl/res_pack.sv
// Result-image bit packer: reads a 128x128 8-bit image one pixel per cycle and
// writes 1024 16-bit words, one bit per pixel, column 16k+j at bit 15-j.
// Optional macro RES_PACK_THRESH_EN adds a threshold input captured at start;
// otherwise a pixel is 1 when non-zero.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   start              - begins a pass when idle or done
//   thresh             - pixel threshold (only with RES_PACK_THRESH_EN)
//   done               - pass complete, held until next accepted start
//   res_rd, res_addr   - image read enable and pixel address
//   res_di             - pixel data for res_addr, same cycle
//   sti_wr, sti_addr,
//   sti_do             - packed word write strobe, word address, data
module res_pack
  import dt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef RES_PACK_THRESH_EN
  input  logic [7:0]           thresh,
`endif
  output logic                 done,
  output logic                 res_rd,
  output logic [RES_AW-1:0]    res_addr,
  input  logic [7:0]           res_di,
  output logic                 sti_wr,
  output logic [STI_AW-1:0]    sti_addr,
  output logic [WORD_BITS-1:0] sti_do
);

  state_e              state_q, state_d;
  logic [RES_AW-1:0]   res_addr_q, res_addr_d;
  logic [STI_AW-1:0]   sti_addr_q;
  logic                accept;
  logic                shift;
  logic                word_last;
  logic                pix_bit;

  always_comb begin
    state_d    = state_q;
    res_addr_d = res_addr_q;
    accept     = 1'b0;
    shift      = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRead;
          accept     = 1'b1;
          res_addr_d = '0;
        end
      end
      StRead: begin
        shift = 1'b1;
        // Hold the final address through LAST instead of wrapping.
        if (res_addr_q == RES_AW'(RES_LAST)) begin
          state_d = StLast;
        end else begin
          res_addr_d = res_addr_q + 1'b1;
        end
      end
      StLast: begin
        state_d    = StDone;
        res_addr_d = '0;
      end
      default: begin
        state_d    = StIdle;
        res_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      res_addr_q <= res_addr_d;
    end
  end

  assign word_last = (res_addr_q[3:0] == 4'hf);

`ifdef RES_PACK_THRESH_EN
  logic [7:0] thresh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_q <= '0;
    end else if (accept) begin
      thresh_q <= thresh;
    end
  end

  assign pix_bit = (res_di >= thresh_q);
`else
  assign pix_bit = (res_di != 8'd0);
`endif

  // Word address rides alongside the completed word; zero when no write.
  always_ff @(posedge clk) begin
    if (reset) begin
      sti_addr_q <= '0;
    end else if (shift && word_last) begin
      sti_addr_q <= res_addr_q[RES_AW-1:4];
    end else begin
      sti_addr_q <= '0;
    end
  end

  pack_shift16 u_shift (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .shift (shift),
    .last  (word_last),
    .din   (pix_bit),
    .word  (sti_do),
    .valid (sti_wr)
  );

  assign done     = (state_q == StDone);
  assign res_rd   = (state_q == StRead);
  assign res_addr = res_addr_q;
  assign sti_addr = sti_addr_q;

endmodule

// File: tb/tb_res_pack.sv
module tb_res_pack;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  thresh;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;

  logic [7:0] img [0:16383];

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } exp_t;
  exp_t q[$];

  int compared;
  int mismatched;

  res_pack dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef RES_PACK_THRESH_EN
    .thresh   (thresh),
`endif
    .done     (done),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do)
  );

  assign res_di = img[res_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic model_bit(input logic [7:0] p);
`ifdef RES_PACK_THRESH_EN
    return p >= thresh;
`else
    return p != 8'd0;
`endif
  endfunction

  task automatic build_expect();
    exp_t e;
    q.delete();
    for (int w = 0; w < 1024; w++) begin
      e.a = w[9:0];
      e.d = '0;
      for (int j = 0; j < 16; j++) e.d[15-j] = model_bit(img[w*16+j]);
      q.push_back(e);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16384; i++) img[i] = 8'd0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rd"}, {31'd0, res_rd}, 32'd0);
    check({tag, "_raddr"}, {18'd0, res_addr}, 32'd0);
    check({tag, "_wr"}, {31'd0, sti_wr}, 32'd0);
    check({tag, "_waddr"}, {22'd0, sti_addr}, 32'd0);
    check({tag, "_do"}, {16'd0, sti_do}, 32'd0);
  endtask

  // One pass: optional ignored start pulses in READ/LAST, optional reset at word 500.
  task automatic run_pass(input bit restart, input bit do_reset);
    int   n;
    bit   fin;
    exp_t e;
    build_expect();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    start = 1'b0;
    check("first_rd", {31'd0, res_rd}, 32'd1);
    check("first_raddr", {18'd0, res_addr}, 32'd0);
    check("first_done", {31'd0, done}, 32'd0);
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = restart && (n == 100 || n == 16384);
      if (sti_wr) begin
        if (q.size() == 0) begin
          check("extra_wr", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("wr_addr", {22'd0, sti_addr}, {22'd0, e.a});
          check("wr_data", {16'd0, sti_do}, {16'd0, e.d});
        end
        if (do_reset && sti_addr == 10'd500) begin
          reset = 1'b1;
          @(posedge clk);
          @(negedge clk);
          reset = 1'b0;
          check_idle_outputs("post_reset");
          for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            check("no_wr_after_reset", {31'd0, sti_wr}, 32'd0);
            check("no_done_after_reset", {31'd0, done}, 32'd0);
          end
          q.delete();
          fin = 1'b1;
        end
      end else begin
        check("idle_waddr", {22'd0, sti_addr}, 32'd0);
        check("idle_do", {16'd0, sti_do}, 32'd0);
      end
      if (!fin && done) begin
        check("done_edge", n, 32'd16385);
        check("done_raddr", {18'd0, res_addr}, 32'd0);
        check("done_rd", {31'd0, res_rd}, 32'd0);
        check("writes_left", q.size(), 32'd0);
        fin = 1'b1;
      end
      if (!fin && n > 17000) begin
        check("done_timeout", 32'd0, 32'd1);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    if (restart) begin
      @(negedge clk);
      check("done_held", {31'd0, done}, 32'd1);
      check("done_no_wr", {31'd0, sti_wr}, 32'd0);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    start      = 1'b0;
    thresh     = 8'd1;
    clear_img();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    // Reset must win over a simultaneous start.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("reset_vs_start_rd", {31'd0, res_rd}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // All-zero image.
    run_pass(1'b0, 1'b0);

    // Mid-pass reset at word 500 on a checkerboard.
    for (int i = 0; i < 16384; i++) img[i] = 8'(((i / 128) + (i % 128)) & 1);
    run_pass(1'b0, 1'b1);

    // Sparse pixels: 0, 15 and 16383.
    clear_img();
    img[0]     = 8'd1;
    img[15]    = 8'd7;
    img[16383] = 8'd255;
    run_pass(1'b0, 1'b0);

    // Checkerboard with ignored start pulses in READ and LAST.
    for (int i = 0; i < 16384; i++) img[i] = 8'(((i / 128) + (i % 128)) & 1);
    run_pass(1'b1, 1'b0);

`ifdef RES_PACK_THRESH_EN
    clear_img();
    img[0] = 8'd4;
    img[1] = 8'd5;
    img[2] = 8'd6;
    thresh = 8'd5;
    run_pass(1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
